// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline: ALU op classes, register
// constants and the packed control bundle carried between stages.
package riscv_pkg;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [4:0] REG_X0 = 5'd0;

    // All-zero value of this bundle is a bubble (no side effects).
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       memto_reg;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection: the instruction in ID reads a
// register that the load currently in EX has not produced yet.
module load_use_detect
    import riscv_pkg::*;
(
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    output logic       lu_hazard_o
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1_i && (id_rs1_i == idex_rd_i);
    assign rs2_match = id_use_rs2_i && (id_rs2_i == idex_rd_i);

    // x0 is hard-wired, so a load targeting it never creates a dependency.
    assign lu_hazard_o = idex_mem_read_i && (idex_rd_i != REG_X0) && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, flush squashing and
// a saturating count of inserted bubbles.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  ID_pc,
    input  logic [XLEN-1:0]  ID_rdata1,
    input  logic [XLEN-1:0]  ID_rdata2,
    input  logic [XLEN-1:0]  ID_imm,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       ID_rd,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             ID_MemWrite,
    input  logic             ID_MemtoReg,
    input  logic             ID_ALUSrc,
    input  logic             ID_Branch,
    input  logic [1:0]       ID_ALUOp,
    input  logic             EX_flush,
    output logic [XLEN-1:0]  IDEX_pc,
    output logic [XLEN-1:0]  IDEX_rdata1,
    output logic [XLEN-1:0]  IDEX_rdata2,
    output logic [XLEN-1:0]  IDEX_imm,
    output logic [4:0]       IDEX_rs1,
    output logic [4:0]       IDEX_rs2,
    output logic [4:0]       IDEX_rd,
    output logic             IDEX_RegWrite,
    output logic             IDEX_MemRead,
    output logic             IDEX_MemWrite,
    output logic             IDEX_MemtoReg,
    output logic             IDEX_ALUSrc,
    output logic             IDEX_Branch,
    output logic [1:0]       IDEX_ALUOp,
    output logic             pc_write,
    output logic             ifid_write,
    output logic [CNT_W-1:0] bubble_cnt
);

    ctrl_t            id_ctrl;
    ctrl_t            ctrl_q, ctrl_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rdata1_q, rdata1_d;
    logic [XLEN-1:0]  rdata2_q, rdata2_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [4:0]       rs1_q, rs1_d;
    logic [4:0]       rs2_q, rs2_d;
    logic [4:0]       rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu_hazard;
    logic             stall;
    logic             load_bubble;

    load_use_detect u_load_use_detect (
        .idex_mem_read_i (ctrl_q.mem_read),
        .idex_rd_i       (rd_q),
        .id_rs1_i        (ID_rs1),
        .id_rs2_i        (ID_rs2),
        .id_use_rs1_i    (ID_use_rs1),
        .id_use_rs2_i    (ID_use_rs2),
        .lu_hazard_o     (lu_hazard)
    );

    // A flush squashes the wrong-path ID instruction anyway, so it must not freeze PC.
    assign stall       = lu_hazard && !EX_flush;
    assign load_bubble = EX_flush || stall;
    assign pc_write    = !stall;
    assign ifid_write  = !stall;

    always_comb begin
        id_ctrl.reg_write = ID_RegWrite;
        id_ctrl.mem_read  = ID_MemRead;
        id_ctrl.mem_write = ID_MemWrite;
        id_ctrl.memto_reg = ID_MemtoReg;
        id_ctrl.alu_src   = ID_ALUSrc;
        id_ctrl.branch    = ID_Branch;
        id_ctrl.alu_op    = ID_ALUOp;
    end

    always_comb begin
        ctrl_d   = '0;
        pc_d     = '0;
        rdata1_d = '0;
        rdata2_d = '0;
        imm_d    = '0;
        rs1_d    = REG_X0;
        rs2_d    = REG_X0;
        rd_d     = REG_X0;
        if (!load_bubble) begin
            ctrl_d   = id_ctrl;
            pc_d     = ID_pc;
            rdata1_d = ID_rdata1;
            rdata2_d = ID_rdata2;
            imm_d    = ID_imm;
            rs1_d    = ID_rs1;
            rs2_d    = ID_rs2;
            rd_d     = ID_rd;
        end

        cnt_d = cnt_q;
        if (load_bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            pc_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            pc_q     <= pc_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

    assign IDEX_pc       = pc_q;
    assign IDEX_rdata1   = rdata1_q;
    assign IDEX_rdata2   = rdata2_q;
    assign IDEX_imm      = imm_q;
    assign IDEX_rs1      = rs1_q;
    assign IDEX_rs2      = rs2_q;
    assign IDEX_rd       = rd_q;
    assign IDEX_RegWrite = ctrl_q.reg_write;
    assign IDEX_MemRead  = ctrl_q.mem_read;
    assign IDEX_MemWrite = ctrl_q.mem_write;
    assign IDEX_MemtoReg = ctrl_q.memto_reg;
    assign IDEX_ALUSrc   = ctrl_q.alu_src;
    assign IDEX_Branch   = ctrl_q.branch;
    assign IDEX_ALUOp    = ctrl_q.alu_op;
    assign bubble_cnt    = cnt_q;

endmodule
